// File: rtl/arbitro_escrita_banco.sv
// -----------------------------------------------------------------------------
// arbitro_escrita_banco
//
// Purpose:
//   Shares the single register-file write port between two writeback sources:
//     A = ALU result
//     B = load data coming back from memory
//   A round-robin arbiter picks one of them. The selected write is registered
//   onto the register-file port (We/Rw/din) one cycle later.
//
//   The block also keeps a 32-entry busy scoreboard. Each set bit marks a
//   destination register that has a write still pending. The issue stage uses
//   it in two ways:
//     - to detect read hazards on the two operands it is issuing (Ra/Rb);
//     - to stall a second producer of a register that is already busy (WAW).
//
//   There is no bypass path. A reader waits until the write has landed.
//
// Parameters:
//   BITS       data width of the register-file write port
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst_n      synchronous reset, active-low
//   a_valid    requester A has a write pending
//   a_ready    A's write accepted this cycle (combinational)
//   a_rd       A destination register
//   a_data     A write data
//   b_valid    requester B has a write pending
//   b_ready    B's write accepted this cycle (combinational)
//   b_rd       B destination register
//   b_data     B write data
//   res_valid  issue stage wants to reserve a destination register
//   res_ready  reservation accepted (combinational)
//   res_rd     register to reserve
//   Ra, Rb     read addresses being issued
//   hazard_a   Ra has a pending write
//   hazard_b   Rb has a pending write
//   We         register-file write enable (registered)
//   Rw         register-file write address (registered)
//   din        register-file write data (registered)
//   busy       scoreboard; bit i set means xi has a pending write
// -----------------------------------------------------------------------------
module arbitro_escrita_banco #(
  parameter int BITS = 64
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            a_valid,
  output logic            a_ready,
  input  logic [4:0]      a_rd,
  input  logic [BITS-1:0] a_data,

  input  logic            b_valid,
  output logic            b_ready,
  input  logic [4:0]      b_rd,
  input  logic [BITS-1:0] b_data,

  input  logic            res_valid,
  output logic            res_ready,
  input  logic [4:0]      res_rd,

  input  logic [4:0]      Ra,
  input  logic [4:0]      Rb,
  output logic            hazard_a,
  output logic            hazard_b,

  output logic            We,
  output logic [4:0]      Rw,
  output logic [BITS-1:0] din,
  output logic [31:0]     busy
);

  // Round-robin pointer: names the requester that wins when both are valid.
  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_t;

  prio_t       prio;
  logic        grant_a;
  logic        grant_b;
  logic        res_take;
  logic [31:0] busy_next;

  // Arbitration.
  //   - A lone valid requester is always granted.
  //   - On contention, the pointer decides who wins.
  //   - The losing requester holds valid (and its rd/data) until its turn.
  //   - Readies are purely combinational.
  always_comb begin
    grant_a = a_valid & (~b_valid | (prio == PRIO_A));
    grant_b = b_valid & (~a_valid | (prio == PRIO_B));
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Reservation handshake.
  //   - A busy register cannot get a second producer, so the reservation
  //     stalls until the pending write has landed.
  //   - x0 is never tracked, so reserving it always succeeds and changes
  //     nothing.
  assign res_ready = ~busy[res_rd] | (res_rd == 5'd0);
  assign res_take  = res_valid & res_ready & (res_rd != 5'd0);

  // Read hazards come straight from the scoreboard (there is no bypass).
  // A bit is only cleared after the write has been presented to the register
  // file for a full cycle. So a reader stays stalled through the cycle in
  // which We writes the register.
  assign hazard_a = busy[Ra];
  assign hazard_b = busy[Rb];

  // Next scoreboard value.
  //   - The write currently on the port clears its bit.
  //   - A new reservation is applied after the clear, so set wins on the
  //     same bit.
  //   - Bit 0 is forced low because x0 is hardwired to zero.
  always_comb begin
    busy_next = busy;
    if (We) begin
      busy_next[Rw] = 1'b0;
    end
    if (res_take) begin
      busy_next[res_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Arbiter state machine and registered write port.
  //   - The granted requester's rd/data go onto the port one cycle after the
  //     handshake.
  //   - Every grant hands priority to the other requester.
  //   - With no grant, We drops and the address/data simply hold.
  //   - A grant to x0 still completes the handshake (and still moves the
  //     pointer) but writes nothing; Rw/din keep their previous values.
  //   - Reset wipes any write that was about to be presented.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio <= PRIO_A;
      We   <= 1'b0;
      Rw   <= 5'd0;
      din  <= '0;
    end else if (grant_a) begin
      prio <= PRIO_B;
      We   <= (a_rd != 5'd0);
      if (a_rd != 5'd0) begin
        Rw  <= a_rd;
        din <= a_data;
      end
    end else if (grant_b) begin
      prio <= PRIO_A;
      We   <= (b_rd != 5'd0);
      if (b_rd != 5'd0) begin
        Rw  <= b_rd;
        din <= b_data;
      end
    end else begin
      We <= 1'b0;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= 32'd0;
    end else begin
      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_arbitro_escrita_banco.sv
// -----------------------------------------------------------------------------
// tb_arbitro_escrita_banco
//
// Purpose:
//   Directed self-checking bench for arbitro_escrita_banco.
//
//   Stimulus:
//     - Driven on the falling clock edge.
//     - A behavioural model of the arbiter pointer, the scoreboard and the
//       write port predicts readies, hazards, busy and We.
//
//   Write checking:
//     - Every accepted write to a non-zero register is pushed into an
//       expected-write queue.
//     - A monitor pops the queue whenever the DUT raises We and compares
//       Rw/din against the popped entry.
// -----------------------------------------------------------------------------
module tb_arbitro_escrita_banco;

  localparam int BITS = 64;

  logic            clk;
  logic            rst_n;
  logic            a_valid;
  logic            a_ready;
  logic [4:0]      a_rd;
  logic [BITS-1:0] a_data;
  logic            b_valid;
  logic            b_ready;
  logic [4:0]      b_rd;
  logic [BITS-1:0] b_data;
  logic            res_valid;
  logic            res_ready;
  logic [4:0]      res_rd;
  logic [4:0]      Ra;
  logic [4:0]      Rb;
  logic            hazard_a;
  logic            hazard_b;
  logic            We;
  logic [4:0]      Rw;
  logic [BITS-1:0] din;
  logic [31:0]     busy;

  typedef struct packed {
    logic [4:0]      rd;
    logic [BITS-1:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          n_checks;
  int          n_fail;

  // Model state, valid as of the next falling edge.
  logic [31:0] m_busy;
  logic        m_we;
  logic [4:0]  m_rw;
  logic        m_prio;

  arbitro_escrita_banco #(.BITS(BITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_rd      (a_rd),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_rd      (b_rd),
    .b_data    (b_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_rd    (res_rd),
    .Ra        (Ra),
    .Rb        (Rb),
    .hazard_a  (hazard_a),
    .hazard_b  (hazard_b),
    .We        (We),
    .Rw        (Rw),
    .din       (din),
    .busy      (busy)
  );

  // 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before end of sequence");
    $fatal(1, "[TB] watchdog");
  end

  // One comparison: counts it, and counts and reports any failure.
  task automatic checkOutput(input string tag, input logic [BITS-1:0] observed,
                             input logic [BITS-1:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Write monitor.
  //   - Every We pulse must match the oldest expected write.
  //   - A pulse with nothing queued is a failure.
  always @(negedge clk) begin
    if (We === 1'b1) begin
      n_checks++;
      assert (exp_q.size() != 0)
      else begin
        n_fail++;
        $error("[TB] FAIL unexpected_write observed Rw=%0d din=%0h expected no write",
               Rw, din);
      end
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        checkOutput("write_Rw", BITS'(Rw), BITS'(e.rd));
        checkOutput("write_din", din, e.data);
      end
    end
  end

  // One cycle of stimulus.
  //   1. Check the registered state against the model.
  //   2. Drive the inputs.
  //   3. Check the combinational outputs.
  //   4. Advance the model to what the next rising edge should produce.
  task automatic applyStimulus(
    input logic av, input logic [4:0] ard, input logic [BITS-1:0] adata,
    input logic bv, input logic [4:0] brd, input logic [BITS-1:0] bdata,
    input logic rv, input logic [4:0] rrd,
    input logic [4:0] ra, input logic [4:0] rb);
    logic        ga;
    logic        gb;
    logic        mres;
    logic [31:0] nb;

    @(negedge clk);
    checkOutput("busy", BITS'(busy), BITS'(m_busy));
    checkOutput("We", BITS'(We), BITS'(m_we));

    a_valid   = av;
    a_rd      = ard;
    a_data    = adata;
    b_valid   = bv;
    b_rd      = brd;
    b_data    = bdata;
    res_valid = rv;
    res_rd    = rrd;
    Ra        = ra;
    Rb        = rb;
    #1;

    ga   = av & (~bv | (m_prio == 1'b0));
    gb   = bv & (~av | (m_prio == 1'b1));
    mres = ~m_busy[rrd] | (rrd == 5'd0);
    checkOutput("a_ready", BITS'(a_ready), BITS'(ga));
    checkOutput("b_ready", BITS'(b_ready), BITS'(gb));
    checkOutput("res_ready", BITS'(res_ready), BITS'(mres));
    checkOutput("hazard_a", BITS'(hazard_a), BITS'(m_busy[ra]));
    checkOutput("hazard_b", BITS'(hazard_b), BITS'(m_busy[rb]));

    // Scoreboard: clear first, then set, so set wins on the same bit.
    nb = m_busy;
    if (m_we) nb[m_rw] = 1'b0;
    if (rv && mres && (rrd != 5'd0)) nb[rrd] = 1'b1;
    nb[0] = 1'b0;
    m_busy = nb;

    // Write port and arbiter pointer.
    if (ga) begin
      m_we   = (ard != 5'd0);
      m_prio = 1'b1;
      if (ard != 5'd0) begin
        m_rw = ard;
        exp_q.push_back('{rd: ard, data: adata});
      end
    end else if (gb) begin
      m_we   = (brd != 5'd0);
      m_prio = 1'b0;
      if (brd != 5'd0) begin
        m_rw = brd;
        exp_q.push_back('{rd: brd, data: bdata});
      end
    end else begin
      m_we = 1'b0;
    end
  endtask

  // Cycles with no requests, only read addresses presented.
  task automatic idle(input int n, input logic [4:0] ra, input logic [4:0] rb);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0, 5'd0, ra, rb);
    end
  endtask

  // Hold reset with both requesters and a reservation active.
  // None of them may reach the register file or the scoreboard.
  task automatic doReset(input int cycles);
    @(negedge clk);
    rst_n     = 1'b0;
    a_valid   = 1'b1;
    a_rd      = 5'd1;
    a_data    = 64'h0101;
    b_valid   = 1'b1;
    b_rd      = 5'd2;
    b_data    = 64'h0202;
    res_valid = 1'b1;
    res_rd    = 5'd4;
    Ra        = 5'd0;
    Rb        = 5'd0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_We", BITS'(We), '0);
    checkOutput("reset_busy", BITS'(busy), '0);
    checkOutput("reset_Rw", BITS'(Rw), '0);
    checkOutput("reset_din", din, '0);
    m_busy = 32'd0;
    m_we   = 1'b0;
    m_rw   = 5'd0;
    m_prio = 1'b0;
    rst_n     = 1'b1;
    a_valid   = 1'b0;
    b_valid   = 1'b0;
    res_valid = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    a_valid   = 1'b0;
    a_rd      = 5'd0;
    a_data    = '0;
    b_valid   = 1'b0;
    b_rd      = 5'd0;
    b_data    = '0;
    res_valid = 1'b0;
    res_rd    = 5'd0;
    Ra        = 5'd0;
    Rb        = 5'd0;
    m_busy    = 32'd0;
    m_we      = 1'b0;
    m_rw      = 5'd0;
    m_prio    = 1'b0;

    $display("[TB] start");

    // Reset with both requesters valid, then A wins first after release.
    doReset(2);
    applyStimulus(1'b1, 5'd1, 64'h11, 1'b1, 5'd2, 64'h22, 1'b0, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b0, 5'd1, 64'h11, 1'b1, 5'd2, 64'h22, 1'b0, 5'd0, 5'd0, 5'd0);
    idle(2, 5'd0, 5'd0);

    // Contention: A wins (pointer back at A), then B gets its turn.
    applyStimulus(1'b1, 5'd5, 64'hAA, 1'b1, 5'd6, 64'hBB, 1'b0, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b0, 5'd5, 64'hAA, 1'b1, 5'd6, 64'hBB, 1'b0, 5'd0, 5'd0, 5'd0);
    idle(2, 5'd0, 5'd0);

    // Scoreboard: x7 reserved, hazard held until the cycle after B writes it.
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd7, 5'd7, 5'd0);
    idle(2, 5'd7, 5'd7);
    applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd7, 64'h7777, 1'b0, 5'd0, 5'd7, 5'd7);
    idle(3, 5'd7, 5'd7);

    // WAW: a second reservation of x9 stalls until the x9 write clears it.
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd9, 5'd0, 5'd0);
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd9, 5'd9, 5'd0);
    applyStimulus(1'b1, 5'd9, 64'h9999, 1'b0, 5'd0, '0, 1'b1, 5'd9, 5'd9, 5'd0);
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd9, 5'd9, 5'd0);
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd9, 5'd9, 5'd0);
    idle(1, 5'd9, 5'd0);
    applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd9, 64'h9A9A, 1'b0, 5'd0, 5'd9, 5'd0);
    idle(2, 5'd9, 5'd0);

    // x0: reservation changes nothing; a write to x0 is accepted but never
    // reaches the port.
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b1, 5'd0, 64'hDEAD, 1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0, 5'd0);
    idle(2, 5'd0, 5'd0);

    // Same-cycle set/clear on x3: reserve x3 while We writes x3.
    applyStimulus(1'b1, 5'd3, 64'h3333, 1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd3, 5'd0);
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd3, 5'd3, 5'd0);
    idle(2, 5'd3, 5'd3);
    applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd3, 64'h3434, 1'b0, 5'd0, 5'd3, 5'd0);
    idle(2, 5'd3, 5'd0);

    // Mid-run reset: the pending x12 reservation and pointer are wiped.
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd12, 5'd0, 5'd0);
    applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd14, 64'h1414, 1'b0, 5'd0, 5'd12, 5'd0);
    doReset(1);
    applyStimulus(1'b1, 5'd13, 64'h1313, 1'b1, 5'd14, 64'h1515, 1'b0, 5'd0, 5'd12, 5'd0);
    applyStimulus(1'b0, 5'd13, 64'h1313, 1'b1, 5'd14, 64'h1515, 1'b0, 5'd0, 5'd12, 5'd0);
    idle(3, 5'd0, 5'd0);

    checkOutput("writes_outstanding", BITS'(exp_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
